// File: rtl/rv_fetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Fetch FSM states plus the default address width and reset vector.
package rv_fetch_queue_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/rv_fifo_sync.sv
// Generic synchronous FIFO: power-of-two depth, synchronous clear,
// head presented from storage registers (zero when empty).
module rv_fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Clear wins over push and pop; pointers wrap on their natural width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && (count == CW'(DEPTH))));

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: single-outstanding bus initiator feeding a
// small prefetch queue; redirects flush the queue and drop stale responses.
module rv_fetch_queue
  import rv_fetch_queue_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_fetch_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc_target,
  output logic            o_bus_req,
  output logic [XLEN-1:0] o_bus_addr,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_data,
  output logic            o_fetch_bus_ack,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_next, pc_d, bus_addr_d, target;
  logic            bus_req_d, push, pop, head_valid;
  logic [CW-1:0]   count, fill_after;
  logic [2*XLEN-1:0] head;

  assign target     = i_pc_target & ~XLEN'(3);
  assign pop        = head_valid & ~i_fetch_stall & ~i_flush;
  assign fill_after = count + CW'(1) - CW'(pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      pc_next    <= RESET_VEC;
      o_bus_req  <= 1'b0;
      o_bus_addr <= RESET_VEC;
    end else begin
      state      <= state_next;
      pc_next    <= pc_d;
      o_bus_req  <= bus_req_d;
      o_bus_addr <= bus_addr_d;
    end
  end

  // Credit check uses the post-push/pop fill so back-to-back fetches stream.
  always_comb begin
    state_next = state;
    pc_d       = pc_next;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_flush) pc_d = target;
        if (i_flush || (count < DEPTH_C)) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (i_flush) begin
          pc_d       = target;
          state_next = i_bus_ack ? ST_IDLE : ST_DRAIN;
        end else if (i_bus_ack) begin
          push       = 1'b1;
          pc_d       = pc_next + XLEN'(4);
          state_next = (fill_after < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (i_flush)   pc_d       = target;
        if (i_bus_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The address only moves when a fresh request is launched; a draining
  // request keeps its original address until the stale ack arrives.
  always_comb begin
    bus_req_d  = (state_next != ST_IDLE);
    bus_addr_d = o_bus_addr;
    if ((state_next == ST_REQ) && ((state != ST_REQ) || i_bus_ack)) bus_addr_d = pc_d;
  end

  rv_fifo_sync #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .push  (push),
    .pop   (pop),
    .wdata ({pc_next, i_bus_data}),
    .head  (head),
    .valid (head_valid),
    .count (count)
  );

  assign o_fetch_bus_ack = head_valid;
  assign o_pc            = head[2*XLEN-1:XLEN];
  assign o_instr         = head[XLEN-1:0];

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Scoreboard bench for rv_fetch_queue: a bus responder queues expected
// {pc, instr} pairs, a monitor checks every instruction decode accepts.
module tb_rv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_fetch_stall, i_flush;
  logic [31:0] i_pc_target;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;
  logic        o_fetch_bus_ack;
  logic [31:0] o_instr, o_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        hold;
  logic [31:0] force_data;

  always #5 clk = ~clk;

  rv_fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_VEC(32'h0)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_fetch_stall   (i_fetch_stall),
    .i_flush         (i_flush),
    .i_pc_target     (i_pc_target),
    .o_bus_req       (o_bus_req),
    .o_bus_addr      (o_bus_addr),
    .i_bus_ack       (i_bus_ack),
    .i_bus_data      (i_bus_data),
    .o_fetch_bus_ack (o_fetch_bus_ack),
    .o_instr         (o_instr),
    .o_pc            (o_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Bus responder: acks a request lat cycles after it first appears; a
  // response is expected at decode only if no redirect hit it in flight.
  initial begin : responder
    logic        pending;
    logic        discard;
    logic [31:0] req_addr;
    int          cnt;
    int          lat;
    pending = 1'b0;
    discard = 1'b0;
    req_addr = '0;
    cnt = 0;
    lat = 1;
    i_bus_ack = 1'b0;
    i_bus_data = '0;
    forever begin
      @(negedge clk);
      i_bus_ack = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (o_bus_req) begin
        if (!pending) begin
          pending  = 1'b1;
          discard  = 1'b0;
          cnt      = 0;
          req_addr = o_bus_addr;
        end
        if (i_flush) discard = 1'b1;
        if (!hold && cnt >= lat) begin
          check("bus_addr_stable", o_bus_addr, req_addr);
          i_bus_data = (force_data != 0) ? force_data : {~req_addr[15:0], req_addr[15:0]};
          i_bus_ack  = 1'b1;
          if (!discard) sb.push_back('{pc: req_addr, data: i_bus_data});
          pending = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every accepted head must match the scoreboard and continue
  // the sequential PC stream from the last reset or redirect.
  initial begin : monitor
    entry_t      e;
    logic [31:0] exp_pc;
    exp_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_pc = 32'h0;
      end else if (i_flush) begin
        sb.delete();
        exp_pc = i_pc_target & 32'hFFFF_FFFC;
      end else if (o_fetch_bus_ack && !i_fetch_stall) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h, expected none", o_pc, o_instr);
        end else begin
          e = sb.pop_front();
          check("instr", o_instr, e.data);
          check("pc", o_pc, e.pc);
          check("pc_seq", o_pc, exp_pc);
          exp_pc += 32'd4;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0; i_fetch_stall = 1'b0; i_flush = 1'b0; i_pc_target = '0;
    hold = 1'b0; force_data = '0;
    repeat (3) @(posedge clk);
    neg();
    check("rst_bus_req", 32'(o_bus_req), 32'd0);
    check("rst_fetch_ack", 32'(o_fetch_bus_ack), 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_bus_addr", o_bus_addr, 32'h0);

    // T1: reset release and streaming
    @(posedge clk); #1 rst_n = 1'b1;
    neg(); check("t1_c0_req", 32'(o_bus_req), 32'd0);
    step(); neg(); check("t1_c1_req", 32'(o_bus_req), 32'd1); check("t1_c1_addr", o_bus_addr, 32'h0);
    step(); neg(); check("t1_c2_ack", 32'(o_fetch_bus_ack), 32'd0);
    step(); neg(); check("t1_c3_ack", 32'(o_fetch_bus_ack), 32'd1); check("t1_c3_pc", o_pc, 32'h0);
    repeat (8) step();

    // T2: backpressure fills exactly two entries
    i_fetch_stall = 1'b1;
    repeat (10) step();
    neg(); check("t2_full_req", 32'(o_bus_req), 32'd0); check("t2_full_ack", 32'(o_fetch_bus_ack), 32'd1);
    step(); i_fetch_stall = 1'b0;
    neg(); check("t2_pop0", 32'(o_fetch_bus_ack), 32'd1);
    step(); neg(); check("t2_pop1", 32'(o_fetch_bus_ack), 32'd1);
    step(); neg(); check("t2_empty", 32'(o_fetch_bus_ack), 32'd0);
    repeat (6) step();

    // T3: redirect with nothing outstanding
    i_fetch_stall = 1'b1;
    repeat (10) step();
    i_flush = 1'b1; i_pc_target = 32'h100;
    step(); i_flush = 1'b0; i_fetch_stall = 1'b0;
    neg(); check("t3_req", 32'(o_bus_req), 32'd1); check("t3_addr", o_bus_addr, 32'h100);
    check("t3_ack_n1", 32'(o_fetch_bus_ack), 32'd0);
    step(); neg(); check("t3_ack_n2", 32'(o_fetch_bus_ack), 32'd0);
    step(); neg(); check("t3_ack_n3", 32'(o_fetch_bus_ack), 32'd1); check("t3_pc", o_pc, 32'h100);
    repeat (6) step();

    // T4: redirect while a request is in flight
    i_fetch_stall = 1'b1;
    repeat (10) step();
    hold = 1'b1; i_flush = 1'b1; i_pc_target = 32'h40;
    step(); i_flush = 1'b0; i_fetch_stall = 1'b0;
    neg(); check("t4_req40", 32'(o_bus_req), 32'd1); check("t4_addr40", o_bus_addr, 32'h40);
    step(); step(); i_flush = 1'b1; i_pc_target = 32'h200;
    step(); i_flush = 1'b0;
    neg(); check("t4_drain_req", 32'(o_bus_req), 32'd1); check("t4_drain_addr", o_bus_addr, 32'h40);
    step();
    step(); hold = 1'b0; force_data = 32'hDEAD;
    step(); force_data = '0;
    neg(); check("t4_idle_req", 32'(o_bus_req), 32'd0);
    step(); neg(); check("t4_new_req", 32'(o_bus_req), 32'd1); check("t4_new_addr", o_bus_addr, 32'h200);
    repeat (6) step();

    // T5a: redirect and ack in the same cycle
    i_fetch_stall = 1'b1;
    repeat (10) step();
    hold = 1'b1; i_flush = 1'b1; i_pc_target = 32'h280;
    step(); i_flush = 1'b0; i_fetch_stall = 1'b0;
    step(); step();
    i_flush = 1'b1; i_pc_target = 32'h300; hold = 1'b0; force_data = 32'hDEAD;
    step(); i_flush = 1'b0; force_data = '0;
    neg(); check("t5_idle_req", 32'(o_bus_req), 32'd0);
    step(); neg(); check("t5_new_req", 32'(o_bus_req), 32'd1); check("t5_new_addr", o_bus_addr, 32'h300);
    repeat (6) step();

    // T5b: redirect and would-be pop in the same cycle
    i_fetch_stall = 1'b1;
    repeat (10) step();
    i_fetch_stall = 1'b0; i_flush = 1'b1; i_pc_target = 32'h400;
    neg(); check("t5b_full", 32'(o_fetch_bus_ack), 32'd1);
    step(); i_flush = 1'b0;
    neg(); check("t5b_empty", 32'(o_fetch_bus_ack), 32'd0);
    check("t5b_req", 32'(o_bus_req), 32'd1); check("t5b_addr", o_bus_addr, 32'h400);
    repeat (6) step();

    // T6: misaligned target, then async reset while draining
    i_fetch_stall = 1'b1;
    repeat (10) step();
    i_flush = 1'b1; i_pc_target = 32'h103;
    step(); i_flush = 1'b0; i_fetch_stall = 1'b0; hold = 1'b1;
    neg(); check("t6_req", 32'(o_bus_req), 32'd1); check("t6_align", o_bus_addr, 32'h100);
    step(); i_flush = 1'b1; i_pc_target = 32'h500;
    step(); i_flush = 1'b0;
    neg(); check("t6_drain_req", 32'(o_bus_req), 32'd1); check("t6_drain_addr", o_bus_addr, 32'h100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req", 32'(o_bus_req), 32'd0);
    check("t6_async_addr", o_bus_addr, 32'h0);
    check("t6_async_ack", 32'(o_fetch_bus_ack), 32'd0);
    hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    neg();
    step(); neg(); check("t6_restart_req", 32'(o_bus_req), 32'd1); check("t6_restart_addr", o_bus_addr, 32'h0);
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
